// File: rtl/road_request_scheduler_if.sv
// Handshake bundle between the road request scheduler and its traffic-light controller.
interface road_request_scheduler_if #(
  parameter int unsigned roads = 4
) ();
  localparam int unsigned roads_size = $clog2(roads);

  logic [roads-1:0]      req;
  logic                  phase_done;
  logic                  start;
  logic [roads_size-1:0] grant_road;
  logic                  grant_valid;
  logic [roads-1:0]      pending;
  logic                  fault;

  modport master (
    output req, phase_done,
    input  start, grant_road, grant_valid, pending, fault
  );

  modport slave (
    input  req, phase_done,
    output start, grant_road, grant_valid, pending, fault
  );
endinterface

// File: rtl/road_request_scheduler.sv
// Round-robin road request scheduler: latches requests, grants one road at a time,
// forces default rotation when idle and flags a stuck controller.
module road_request_scheduler #(
  parameter int unsigned roads      = 4,
  parameter int unsigned idle_limit = 15,
  parameter int unsigned wait_limit = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  road_request_scheduler_if.slave  bus
);
  localparam int unsigned roads_size = $clog2(roads);
  localparam int unsigned idle_w     = (idle_limit > 0) ? $clog2(idle_limit + 1) : 1;
  localparam int unsigned wait_w     = (wait_limit > 0) ? $clog2(wait_limit + 1) : 1;

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_select = 2'd1;
  localparam logic [1:0] st_start  = 2'd2;
  localparam logic [1:0] st_wait   = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [roads_size-1:0] r_grant_road;
  logic [roads_size-1:0] r_rr_ptr;
  logic [roads-1:0]      r_pending;
  logic                  r_start;
  logic                  r_grant_valid;
  logic                  r_fault;
  logic [idle_w-1:0]     r_idle_cnt;
  logic [wait_w-1:0]     r_wait_cnt;

  logic [roads_size-1:0] w_winner;
  logic                  w_hit;
  logic                  w_any_pending;
  logic                  w_idle_expire;
  logic                  w_wait_expire;
  logic [roads-1:0]      w_clr;

  assign w_any_pending = |r_pending;
  assign w_idle_expire = (idle_limit != 0) && (r_idle_cnt == idle_w'(idle_limit - 1));
  assign w_wait_expire = (r_wait_cnt == wait_w'(wait_limit));

  // First pending road at or after rr_ptr, modulo roads.
  always_comb begin
    w_winner = r_rr_ptr;
    w_hit    = 1'b0;
    for (int unsigned i = 0; i < roads; i++) begin
      if (!w_hit && r_pending[roads_size'((32'(r_rr_ptr) + i) % roads)]) begin
        w_winner = roads_size'((32'(r_rr_ptr) + i) % roads);
        w_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_state == st_start) w_clr = roads'(1) << r_grant_road;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= st_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      st_idle: begin
        if (w_any_pending)      w_next = st_select;
        else if (w_idle_expire) w_next = st_select;
      end
      st_select: w_next = st_start;
      st_start:  w_next = st_wait;
      st_wait: begin
        if (bus.phase_done)     w_next = st_idle;
        else if (w_wait_expire) w_next = st_idle;
      end
      default:   w_next = st_idle;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_road  <= '0;
      r_rr_ptr      <= '0;
      r_pending     <= '0;
      r_start       <= 1'b0;
      r_grant_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_idle_cnt    <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_pending     <= (r_pending & ~w_clr) | bus.req;
      r_start       <= (w_next == st_start);
      r_grant_valid <= (w_next == st_start) || (w_next == st_wait);

      if (r_state == st_select)
        r_grant_road <= w_any_pending ? w_winner : r_rr_ptr;

      if (r_state == st_start)
        r_rr_ptr <= (r_grant_road == roads_size'(roads - 1)) ? '0
                                                             : r_grant_road + roads_size'(1);

      if ((r_state == st_idle) && !w_any_pending && (idle_limit != 0) && !w_idle_expire)
        r_idle_cnt <= r_idle_cnt + idle_w'(1);
      else
        r_idle_cnt <= '0;

      if ((r_state == st_wait) && (w_next == st_wait))
        r_wait_cnt <= r_wait_cnt + wait_w'(1);
      else
        r_wait_cnt <= '0;

      // A phase_done arriving on the last allowed cycle still counts as success.
      if ((r_state == st_wait) && !bus.phase_done && w_wait_expire)
        r_fault <= 1'b1;
    end
  end

  assign bus.start       = r_start;
  assign bus.grant_road  = r_grant_road;
  assign bus.grant_valid = r_grant_valid;
  assign bus.pending     = r_pending;
  assign bus.fault       = r_fault;
endmodule

// File: tb/tb_road_request_scheduler.sv
// Scoreboard bench for road_request_scheduler: expected grant roads are queued with
// the stimulus and checked on every start pulse; timing points are checked inline.
module tb_road_request_scheduler;
  localparam int unsigned roads = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  road_request_scheduler_if #(.roads(roads)) bus ();

  road_request_scheduler #(
    .roads(roads), .idle_limit(15), .wait_limit(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_q[$];
  logic        prev_start = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Every start pulse: one cycle wide, with grant_valid, and the next queued road.
  always @(negedge clk) begin
    if (bus.start === 1'b1) begin
      check_eq("start_single", 32'(prev_start), 32'd0);
      check_eq("start_gv", 32'(bus.grant_valid), 32'd1);
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   check_eq("grant_road", 32'(bus.grant_road), exp_q.pop_front());
    end
    prev_start <= bus.start;
  end

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (bus.start === 1'b1) seen = 1'b1;
    end
    if (!seen) check_eq("start_timeout", 32'(seen), 32'd1);
  endtask

  task automatic finish_phase(input int unsigned after);
    repeat (after) tick();
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    check_eq("gv_after_done", 32'(bus.grant_valid), 32'd0);
  endtask

  task automatic ticks_to_start(output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
      bus.phase_done = 1'b0;
    end while (bus.start !== 1'b1 && n < 60);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, 32'(bus.start), 32'd0);
    check_eq({tag, "_gv"},    32'(bus.grant_valid), 32'd0);
    check_eq({tag, "_road"},  32'(bus.grant_road), 32'd0);
    check_eq({tag, "_pend"},  32'(bus.pending), 32'd0);
    check_eq({tag, "_fault"}, 32'(bus.fault), 32'd0);
  endtask

  int unsigned n;

  initial begin
    bus.req        = '0;
    bus.phase_done = 1'b0;
    reset          = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst0");
    reset = 1'b0;
    tick();

    // Single request on road 2: start three cycles after req.
    exp_q.push_back(2);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    check_eq("t1_pend", 32'(bus.pending), 32'h4);
    check_eq("t1_start_k1", 32'(bus.start), 32'd0);
    tick();
    check_eq("t1_start_k2", 32'(bus.start), 32'd0);
    tick();
    check_eq("t1_start_k3", 32'(bus.start), 32'd1);
    tick();
    check_eq("t1_pend_clr", 32'(bus.pending), 32'd0);
    check_eq("t1_gv_wait", 32'(bus.grant_valid), 32'd1);
    check_eq("t1_start_k4", 32'(bus.start), 32'd0);
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    check_eq("t1_gv_done", 32'(bus.grant_valid), 32'd0);

    // rr_ptr is now 3: wrap-around order 3 then 0; reset abandons the second grant.
    exp_q.push_back(3);
    exp_q.push_back(0);
    bus.req = 4'b1001;
    tick();
    bus.req = '0;
    wait_start();
    finish_phase(5);
    wait_start();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_gv", 32'(bus.grant_valid), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst1");

    // rr_ptr back to 0: 4'b1011 served as 0, 1, 3.
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    bus.req = 4'b1011;
    tick();
    bus.req = '0;
    wait_start();
    finish_phase(5);
    wait_start();
    finish_phase(5);
    wait_start();
    repeat (5) tick();
    check_eq("t2_pend", 32'(bus.pending), 32'd0);

    // Idle rotation: default grants to rr_ptr (0, then 1).
    exp_q.push_back(0);
    exp_q.push_back(1);
    bus.phase_done = 1'b1;
    ticks_to_start(n);
    check_eq("idle_latency", 32'(n), 32'd17);
    tick();
    bus.phase_done = 1'b1;
    ticks_to_start(n);
    check_eq("idle_period", 32'(n + 1), 32'd18);
    finish_phase(5);

    // req[2] held through its START: re-granted after roads 0 and 1.
    exp_q.push_back(2);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    bus.req = 4'b0111;
    tick();
    bus.req = 4'b0100;
    wait_start();
    tick();
    check_eq("hold_pend", 32'(bus.pending), 32'h7);
    bus.req = '0;
    finish_phase(4);
    for (int g = 0; g < 3; g++) begin
      wait_start();
      finish_phase(5);
    end
    check_eq("hold_pend_end", 32'(bus.pending), 32'd0);

    // Watchdog: no phase_done for road 0 with wait_limit 8.
    exp_q.push_back(0);
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    wait_start();
    repeat (9) tick();
    check_eq("wd_fault_pre", 32'(bus.fault), 32'd0);
    check_eq("wd_gv_pre", 32'(bus.grant_valid), 32'd1);
    tick();
    check_eq("wd_fault", 32'(bus.fault), 32'd1);
    check_eq("wd_gv", 32'(bus.grant_valid), 32'd0);
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    check_eq("wd_ignored_gv", 32'(bus.grant_valid), 32'd0);
    check_eq("wd_ignored_fault", 32'(bus.fault), 32'd1);

    // Scheduling continues with fault set: default grant to road 1.
    exp_q.push_back(1);
    wait_start();
    finish_phase(5);
    check_eq("fault_sticky", 32'(bus.fault), 32'd1);

    reset = 1'b1;
    repeat (2) tick();
    check_reset_outputs("rst2");
    reset = 1'b0;
    tick();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
